// File: rtl/mux_4to1_if.sv
// Bundle of data, select, enable and result signals for the 4:1 steering mux.
// The master side drives data/select/enable; the slave (the mux) returns results.
interface mux_4to1_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] y;
  logic [1:0]       sel_q;

  modport master (
    output en, i0, i1, i2, i3, s0, s1,
    input  y_comb, y, sel_q
  );

  modport slave (
    input  en, i0, i1, i2, i3, s0, s1,
    output y_comb, y, sel_q
  );
endinterface

// File: rtl/mux_4to1.sv
// Four-input data mux with a zero-latency output and an enabled, registered copy.
// Select index is {s0,s1} with s0 as the MSB; the registered select tracks y.
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input logic       clk,
  input logic       rst,
  mux_4to1_if.slave bus
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] y_comb_d;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       sel_q;

  assign sel = {bus.s0, bus.s1};

  always_comb begin
    // NOTE: every path assigns y_comb_d (default arm included), so no latch is inferred.
    // An X/Z select matches no explicit arm and drives zeros in simulation.
    case (sel)
      2'b00:   y_comb_d = bus.i0;
      2'b01:   y_comb_d = bus.i1;
      2'b10:   y_comb_d = bus.i2;
      2'b11:   y_comb_d = bus.i3;
      default: y_comb_d = '0;
    endcase
  end

  // Reset wins over enable; with en low both registers simply hold.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (rst) begin
      y_q   <= '0;
      sel_q <= 2'b00;
    end else if (bus.en) begin
      y_q   <= y_comb_d;
      sel_q <= sel;
    end
  end

  assign bus.y_comb = y_comb_d;
  assign bus.y      = y_q;
  assign bus.sel_q  = sel_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Scoreboard bench for mux_4to1: stimulus pushes expected registered results,
// an independent monitor pops and compares them one clock later.
module tb_mux_4to1;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_4to1_if #(.WIDTH(W)) bus ();
  mux_4to1 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [W-1:0] y;
    logic [1:0]   sel;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] ref_y   = '0;
  logic [1:0]   ref_sel = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, check the combinational output, queue the registered expectation.
  task automatic drive(input logic r, input logic e, input logic [1:0] sel,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] din[4];
    @(negedge clk);
    rst    = r;
    bus.en = e;
    bus.i0 = a;
    bus.i1 = b;
    bus.i2 = c;
    bus.i3 = d;
    bus.s0 = sel[1];
    bus.s1 = sel[0];
    din = '{a, b, c, d};
    #1 check("y_comb", 32'(bus.y_comb), 32'(din[sel]));
    if (r) begin
      ref_y   = '0;
      ref_sel = 2'b00;
    end else if (e) begin
      ref_y   = din[sel];
      ref_sel = sel;
    end
    sb_q.push_back('{y: ref_y, sel: ref_sel});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("y", 32'(bus.y), 32'(mon_e.y));
        check("sel_q", 32'(bus.sel_q), 32'(mon_e.sel));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] v[4];
    rst    = 1'b1;
    bus.en = 1'b0;
    bus.i0 = '0; bus.i1 = '0; bus.i2 = '0; bus.i3 = '0;
    bus.s0 = 1'b0; bus.s1 = 1'b0;

    // Reset, with data present so y_comb is seen to ignore reset.
    drive(1, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h5A);
    drive(1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // One-hot walk, each vector held for two cycles, then back to i0.
    for (int k = 0; k < 4; k++) begin
      v = '{default: '0};
      v[k] = 8'h01;
      repeat (2) drive(0, 1, 2'(k), v[0], v[1], v[2], v[3]);
    end
    drive(0, 1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);

    // Negative selection: a single hot input that is not the selected one.
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 4; j++) begin
        if (j != s) begin
          v = '{default: '0};
          v[j] = 8'hFF;
          drive(0, 1, 2'(s), v[0], v[1], v[2], v[3]);
        end
      end
    end

    // Select ordering: {s0,s1}=01 picks i1, 10 picks i2.
    drive(0, 1, 2'b01, 8'h00, 8'h00, 8'h01, 8'h00);
    drive(0, 1, 2'b10, 8'h00, 8'h00, 8'h01, 8'h00);

    // Enable hold for three cycles while inputs change, then reload.
    drive(0, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);
    drive(0, 0, 2'b00, 8'h00, 8'h01, 8'h01, 8'h01);
    drive(0, 0, 2'b01, 8'h01, 8'h00, 8'h01, 8'h01);
    drive(0, 0, 2'b10, 8'h01, 8'h01, 8'h00, 8'h01);
    drive(0, 1, 2'b10, 8'h01, 8'h01, 8'h00, 8'h01);

    // Mid-stream reset with en high, then reload on deassertion.
    drive(0, 1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(1, 1, 2'b01, 8'h01, 8'h01, 8'h00, 8'h00);
    drive(0, 1, 2'b01, 8'h01, 8'h01, 8'h00, 8'h00);

    // Full-width pattern stepping through every select.
    for (int s = 0; s < 4; s++)
      drive(0, 1, 2'(s), 8'hA5, 8'h3C, 8'hF0, 8'h0F);

    // Randomized traffic with occasional reset and enable toggling.
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(15) == 0), 1'($urandom), 2'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    @(posedge clk);
    #3;
    check("drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_4to1.md
Name:
mux_4to1

Overview:
- Four-input, one-output data multiplexer with a 2-bit select formed from two single-bit select lines.
- Provides an immediate combinational output and a clocked, registered copy of the selected data for use in synchronous datapaths.
- Leaf-level datapath steering block; no internal state beyond the output and select registers.

Parameters:
- WIDTH, 1, bit width of each data input and of both data outputs.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  register load enable for y and sel_q.
- i0  input  WIDTH  data input, selected when {s0,s1} = 2'b00.
- i1  input  WIDTH  data input, selected when {s0,s1} = 2'b01.
- i2  input  WIDTH  data input, selected when {s0,s1} = 2'b10.
- i3  input  WIDTH  data input, selected when {s0,s1} = 2'b11.
- s0  input  1  select MSB.
- s1  input  1  select LSB.
- y_comb  output  WIDTH  combinational mux output.
- y  output  WIDTH  registered mux output.
- sel_q  output  2  registered select index {s0,s1} matching the current y.

Behaviour:
- Select index is sel = {s0,s1}, with s0 as the MSB. Note the ordering: s0=0,s1=1 selects i1; s0=1,s1=0 selects i2.
- Combinational output:
  - y_comb = i0 / i1 / i2 / i3 for sel = 00 / 01 / 10 / 11.
  - Zero-latency; y_comb follows any input or select change with no clock involvement.
  - If s0 or s1 is X/Z, y_comb is driven to all zeros. This is simulation behaviour only; synthesis treats it as don't-care.
- Registered path, evaluated on each rising clk edge:
  - rst=1: y <= 0 and sel_q <= 2'b00. Reset has priority over en.
  - rst=0 and en=1: y <= y_comb and sel_q <= {s0,s1}. Latency is 1 clock.
  - rst=0 and en=0: y and sel_q hold their values.
- Reset values: y = {WIDTH{1'b0}}, sel_q = 2'b00. y_comb is not reset; it always reflects the current inputs.
- Reset asserted mid-stream: y clears at the first rising edge with rst=1, regardless of en or data. The first load after deassertion occurs at the first edge with rst=0 and en=1.
- Data and select changing in the same cycle: the registered value uses the data and select values sampled together at that edge. No cross-cycle mixing.
- Inputs are not registered; no handshake is used.
- All WIDTH bits are steered identically. No arithmetic is performed and no widths are extended.

Test Plan:
- One-hot walk, en=1, WIDTH=1, each vector held for 20 ns:
  - i0=1 (others 0), s0=0,s1=0 -> y_comb=1 immediately; y=1 and sel_q=00 after the next edge.
  - i1=1, s0=0,s1=1 -> y_comb=1; y=1 and sel_q=01 after the edge.
  - i2=1, s0=1,s1=0 -> y_comb=1; y=1 and sel_q=10 after the edge.
  - i3=1, s0=1,s1=1 -> y_comb=1; y=1 and sel_q=11 after the edge.
  - Return to i0=1, sel=00 -> y=1.
- Negative selection: i1=1 with other inputs 0, sel=00 -> y_comb=0 and y=0. Repeat for every non-selected input.
- Ordering check: i1=0, i2=1, s0=0,s1=1 -> y_comb=0. Then s0=1,s1=0 -> y_comb=1.
- Enable hold: load y=1, then set en=0 and change inputs so y_comb=0 for 3 cycles -> y stays 1 and sel_q is unchanged. Raise en -> y=0 after one edge.
- Reset: with y=1 and en=1, assert rst for 1 cycle -> y=0 and sel_q=00 at that edge while y_comb keeps following the inputs. Deassert rst -> y reloads at the next edge.
- WIDTH=8: i0=8'hA5, i1=8'h3C, i2=8'hF0, i3=8'h0F, stepping sel through 00/01/10/11 -> y = A5, 3C, F0, 0F, each one cycle after the corresponding select.
